tpu_act_feeder: RTL and testbench

Activation feeder for the N×N systolic array. A host fills an internal row buffer with activation rows, each holding N packed 8-bit lanes. On `start` the block streams the rows into the array's left-edge inputs with the diagonal skew the array requires, and drives the array enable. It sits directly upstream of the array's packed activation input bus and its `en` input, and is the transmit end of that interface.

---
 rtl/tpu_act_feeder.sv | 172 +++++++++++++++++
 tb/tb_tpu_act_feeder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_act_feeder.sv
// tpu_act_feeder
//   Activation feeder for an N x N systolic array. A host fills a row buffer
//   with activation rows of N packed lanes; on start the rows are streamed to
//   the array's left edge with diagonal skew (lane k delayed by k cycles),
//   followed by zero rows so the array can drain.
//
// Configuration macro: TPU_FEEDER_FLUSH_EN
//   defined   : zero padding for 2N-2 cycles after the last row (full drain)
//   undefined : zero padding for N-1 cycles (last skewed datum leaves lane N-1)
//
// Ports
//   clk     in   clock, all logic on posedge
//   rst     in   asynchronous active-low reset
//   we      in   row-buffer write strobe (honoured only while idle)
//   adr_w   in   row index to write
//   dat_i   in   row data, lane k = [k*DWIDTH +: DWIDTH]
//   start   in   begin streaming (sampled only while idle)
//   len     in   rows to stream (clamped to buffer depth), sampled with start
//   lane_o  out  skewed activations, registered
//   en_o    out  array enable, registered
//   busy    out  high whenever not idle
//   done    out  one-cycle pulse after the last en_o cycle
module tpu_act_feeder #(
    parameter int N      = 3,
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [AWIDTH-1:0]   adr_w,
    input  logic [N*DWIDTH-1:0] dat_i,
    input  logic                start,
    input  logic [AWIDTH:0]     len,
    output logic [N*DWIDTH-1:0] lane_o,
    output logic                en_o,
    output logic                busy,
    output logic                done
);

`ifdef TPU_FEEDER_FLUSH_EN
    localparam int FL = 2 * N - 2;
`else
    localparam int FL = N - 1;
`endif
    localparam int FW = (FL < 1) ? 1 : $clog2(FL + 1);
    localparam logic [FW-1:0] FL_L = FW'(FL);
    localparam logic [AWIDTH:0] DEPTH_L = {1'b1, {AWIDTH{1'b0}}};
    // Triangular delay storage: lane k owns k stages, k*(k-1)/2 is its base.
    localparam int TRI = (N * (N - 1)) / 2;
    localparam int TW  = ((TRI > 0) ? TRI : 1) * DWIDTH;

    typedef enum logic [1:0] {IDLE, FEED, FLUSH, DONE} state_t;

    logic [N*DWIDTH-1:0] row_mem [2**AWIDTH];

    state_t              state_q, state_d;
    logic [AWIDTH:0]     cnt_q, cnt_d;
    logic [AWIDTH:0]     len_q, len_d;
    logic [FW-1:0]       fcnt_q, fcnt_d;
    logic [N*DWIDTH-1:0] rd_q, rd_d;
    logic                v_q, v_d;
    logic                en_q;
    logic                done_q;
    logic [N*DWIDTH-1:0] lane_q, lane_d;
    logic [TW-1:0]       tri_q, tri_d;

    // Row buffer: no reset, so contents survive a mid-stream abort.
    always_ff @(posedge clk) begin
        if (we && (state_q == IDLE)) begin
            row_mem[adr_w] <= dat_i;
        end
    end

    // FLUSH runs FL+1 cycles but raises the valid only for the first FL:
    // the extra cycle, plus DONE itself, covers the read and output register
    // latency so the done pulse lands right after the last en_o cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        fcnt_d  = fcnt_q;
        rd_d    = '0;
        v_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        len_d   = (len > DEPTH_L) ? DEPTH_L : len;
                        cnt_d   = '0;
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                rd_d  = row_mem[cnt_q[AWIDTH-1:0]];
                v_d   = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_d == len_q) begin
                    fcnt_d  = '0;
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                v_d    = (fcnt_q < FL_L);
                fcnt_d = fcnt_q + 1'b1;
                if (fcnt_q == FL_L) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Skew network: lane 0 goes straight to the output register, lane k
    // walks through k stages first. Zero reads feed the bubbles.
    always_comb begin
        tri_d  = '0;
        lane_d = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (k == 0) begin
                lane_d[0 +: DWIDTH] = rd_q[0 +: DWIDTH];
            end else begin
                tri_d[(k*(k-1)/2)*DWIDTH +: DWIDTH] = rd_q[k*DWIDTH +: DWIDTH];
                for (int unsigned j = 1; j < k; j++) begin
                    tri_d[(k*(k-1)/2+j)*DWIDTH +: DWIDTH] =
                        tri_q[(k*(k-1)/2+j-1)*DWIDTH +: DWIDTH];
                end
                lane_d[k*DWIDTH +: DWIDTH] = tri_q[(k*(k-1)/2+k-1)*DWIDTH +: DWIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            fcnt_q  <= '0;
            rd_q    <= '0;
            v_q     <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            lane_q  <= '0;
            tri_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            fcnt_q  <= fcnt_d;
            rd_q    <= rd_d;
            v_q     <= v_d;
            en_q    <= v_q;
            done_q  <= (state_q == DONE);
            lane_q  <= lane_d;
            tri_q   <= tri_d;
        end
    end

    assign lane_o = lane_q;
    assign en_o   = en_q;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;

endmodule

// File: tb/tb_tpu_act_feeder.sv
module tb_tpu_act_feeder;

`ifdef TPU_FEEDER_FLUSH_EN
    localparam int FL = 4;
`else
    localparam int FL = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  adr_w;
    logic [23:0] dat_i;
    logic        start;
    logic [4:0]  len;
    logic [23:0] lane_o;
    logic        en_o;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [23:0] mem_m [16];
    logic        cap_en   [40];
    logic        cap_done [40];
    logic        cap_busy [40];
    logic [23:0] cap_lane [40];

    tpu_act_feeder #(.N(3), .DWIDTH(8), .AWIDTH(4)) dut (
        .clk(clk), .rst(rst), .we(we), .adr_w(adr_w), .dat_i(dat_i),
        .start(start), .len(len), .lane_o(lane_o), .en_o(en_o),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] exp_lane(input int s, input int k, input int l);
        logic [23:0] row;
        if (s - k >= 0 && s - k < l) begin
            row = mem_m[s-k];
            return row[k*8 +: 8];
        end
        return 8'h00;
    endfunction

    task automatic write_row(input int a, input logic [23:0] d);
        @(negedge clk);
        we = 1'b1; adr_w = 4'(a); dat_i = d;
        @(negedge clk);
        we = 1'b0;
        mem_m[a] = d;
    endtask

    // Called at a negedge: drives start now, then captures cycles t=0.. after edge E.
    task automatic run_stream(input logic [4:0] l, input int ncyc, input bit poke);
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0; len = 5'd0;
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            cap_en[t] = en_o; cap_done[t] = done; cap_busy[t] = busy; cap_lane[t] = lane_o;
            if (poke && t == 2) begin
                start = 1'b1; len = 5'd9; we = 1'b1; adr_w = 4'd1; dat_i = 24'hFFFFFF;
            end
            if (poke && t == 3) begin
                start = 1'b0; len = 5'd0; we = 1'b0;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; we = 1'b0; adr_w = '0; dat_i = '0; start = 1'b0; len = '0;
        #2 rst = 1'b0;
        #2;
        checks++; if (lane_o !== 24'h0) begin errors++; $display("FAIL reset_lane got %h exp 000000", lane_o); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", en_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic_skew;
        logic [7:0] tab [3][7];
        int s, ecnt;
        logic [7:0] ev;
        tab[0] = '{8'h01, 8'h04, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
        tab[1] = '{8'h00, 8'h02, 8'h05, 8'h08, 8'h00, 8'h00, 8'h00};
        tab[2] = '{8'h00, 8'h00, 8'h03, 8'h06, 8'h09, 8'h00, 8'h00};
        write_row(0, 24'h030201);
        write_row(1, 24'h060504);
        write_row(2, 24'h090807);
        run_stream(5'd3, 12, 1'b0);
        ecnt = 0;
        for (int t = 0; t < 12; t++) begin
            s = t - 2;
            if (cap_en[t] === 1'b1) ecnt++;
            checks++;
            if (cap_en[t] !== (t >= 2 && t < 2 + 3 + FL)) begin
                errors++; $display("FAIL basic_en t=%0d got %b", t, cap_en[t]);
            end
            checks++;
            if (cap_done[t] !== (t == 2 + 3 + FL)) begin
                errors++; $display("FAIL basic_done t=%0d got %b", t, cap_done[t]);
            end
            checks++;
            if (cap_busy[t] !== (t < 2 + 3 + FL)) begin
                errors++; $display("FAIL basic_busy t=%0d got %b", t, cap_busy[t]);
            end
            for (int k = 0; k < 3; k++) begin
                ev = (s >= 0 && s < 7) ? tab[k][s] : 8'h00;
                checks++;
                if (cap_lane[t][k*8 +: 8] !== ev) begin
                    errors++; $display("FAIL basic_lane t=%0d k=%0d got %h exp %h", t, k, cap_lane[t][k*8 +: 8], ev);
                end
            end
        end
        checks++;
        if (ecnt != 3 + FL) begin errors++; $display("FAIL basic_en_len got %0d exp %0d", ecnt, 3 + FL); end
    endtask

    task automatic test_len0;
        run_stream(5'd0, 6, 1'b0);
        for (int t = 0; t < 6; t++) begin
            checks++;
            if (cap_done[t] !== (t == 1)) begin errors++; $display("FAIL len0_done t=%0d got %b", t, cap_done[t]); end
            checks++;
            if (cap_en[t] !== 1'b0) begin errors++; $display("FAIL len0_en t=%0d got %b exp 0", t, cap_en[t]); end
            checks++;
            if (cap_lane[t] !== 24'h0) begin errors++; $display("FAIL len0_lane t=%0d got %h exp 000000", t, cap_lane[t]); end
        end
    endtask

    task automatic test_clamp;
        int ecnt, dcnt;
        logic [7:0] ev;
        for (int r = 0; r < 16; r++) write_row(r, {8'(8'h30 + r), 8'(8'h20 + r), 8'(8'h10 + r)});
        run_stream(5'd20, 30, 1'b0);
        ecnt = 0; dcnt = 0;
        for (int t = 0; t < 30; t++) begin
            if (cap_en[t] === 1'b1) ecnt++;
            if (cap_done[t] === 1'b1) dcnt++;
            for (int k = 0; k < 3; k++) begin
                ev = exp_lane(t - 2, k, 16);
                checks++;
                if (cap_lane[t][k*8 +: 8] !== ev) begin
                    errors++; $display("FAIL clamp_lane t=%0d k=%0d got %h exp %h", t, k, cap_lane[t][k*8 +: 8], ev);
                end
            end
        end
        checks++;
        if (ecnt != 16 + FL) begin errors++; $display("FAIL clamp_en_len got %0d exp %0d", ecnt, 16 + FL); end
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL clamp_done_count got %0d exp 1", dcnt); end
        checks++;
        if (cap_done[2 + 16 + FL] !== 1'b1) begin errors++; $display("FAIL clamp_done_pos got %b exp 1", cap_done[2 + 16 + FL]); end
    endtask

    task automatic test_ignored_inputs;
        int ecnt, dcnt;
        logic [7:0] ev;
        run_stream(5'd4, 16, 1'b1);
        ecnt = 0; dcnt = 0;
        for (int t = 0; t < 16; t++) begin
            if (cap_en[t] === 1'b1) ecnt++;
            if (cap_done[t] === 1'b1) dcnt++;
        end
        checks++;
        if (ecnt != 4 + FL) begin errors++; $display("FAIL ign_en_len got %0d exp %0d", ecnt, 4 + FL); end
        checks++;
        if (dcnt != 1) begin errors++; $display("FAIL ign_done_count got %0d exp 1", dcnt); end
        checks++;
        if (cap_done[2 + 4 + FL] !== 1'b1) begin errors++; $display("FAIL ign_done_pos got %b exp 1", cap_done[2 + 4 + FL]); end
        run_stream(5'd4, 12, 1'b0);
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 3; k++) begin
                ev = exp_lane(t - 2, k, 4);
                checks++;
                if (cap_lane[t][k*8 +: 8] !== ev) begin
                    errors++; $display("FAIL ign_lane t=%0d k=%0d got %h exp %h", t, k, cap_lane[t][k*8 +: 8], ev);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        run_stream(5'd2, 5 + FL, 1'b0);
        checks++;
        if (cap_done[4 + FL] !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b exp 1", cap_done[4 + FL]); end
        checks++;
        if (cap_busy[4 + FL] !== 1'b0) begin errors++; $display("FAIL b2b_busy_low got %b exp 0", cap_busy[4 + FL]); end
        run_stream(5'd2, 10, 1'b0);
        checks++;
        if (cap_busy[0] !== 1'b1) begin errors++; $display("FAIL b2b_busy2 got %b exp 1", cap_busy[0]); end
        checks++;
        if (cap_en[1] !== 1'b0) begin errors++; $display("FAIL b2b_en_early got %b exp 0", cap_en[1]); end
        checks++;
        if (cap_en[2] !== 1'b1) begin errors++; $display("FAIL b2b_en_first got %b exp 1", cap_en[2]); end
        checks++;
        if (cap_lane[2][7:0] !== 8'h10) begin errors++; $display("FAIL b2b_lane0 got %h exp 10", cap_lane[2][7:0]); end
        checks++;
        if (cap_done[4 + FL] !== 1'b1) begin errors++; $display("FAIL b2b_done2 got %b exp 1", cap_done[4 + FL]); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] ev;
        run_stream(5'd4, 3, 1'b0);
        checks++;
        if (en_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_en got %b exp 1", en_o); end
        #2 rst = 1'b0;
        #1;
        checks++; if (lane_o !== 24'h0) begin errors++; $display("FAIL rmid_lane got %h exp 000000", lane_o); end
        checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL rmid_en got %b exp 0", en_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b exp 0", done); end
        @(negedge clk);
        rst = 1'b1;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++; $display("FAIL rmid_after t=%0d busy %b done %b exp 0 0", t, busy, done);
            end
        end
        run_stream(5'd4, 14, 1'b0);
        for (int t = 0; t < 14; t++) begin
            for (int k = 0; k < 3; k++) begin
                ev = exp_lane(t - 2, k, 4);
                checks++;
                if (cap_lane[t][k*8 +: 8] !== ev) begin
                    errors++; $display("FAIL rmid_lane t=%0d k=%0d got %h exp %h", t, k, cap_lane[t][k*8 +: 8], ev);
                end
            end
        end
        checks++;
        if (cap_done[2 + 4 + FL] !== 1'b1) begin errors++; $display("FAIL rmid_done_pos got %b exp 1", cap_done[2 + 4 + FL]); end
    endtask

    initial begin
        test_reset;
        test_basic_skew;
        test_len0;
        test_clamp;
        test_ignored_inputs;
        test_back_to_back;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
